instr_fetch: RTL and testbench

//  Program-fetch stage directly upstream of the instruction control LUT.

---
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Program-fetch stage feeding the instruction control LUT. Holds the PC,
//   runs a single-outstanding req/ack read on program memory, captures the
//   returned word into the instruction register and offers it to decode with
//   a valid/ready handshake. The next PC is chosen by pcInMux_ctrl on the
//   handshake; flush redirects the PC and has priority over everything else.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pm_req/pm_addr    program-memory read request and address (held until ack)
//   pm_ack/pm_rdata   read completion and returned word (ack may share the
//                     cycle in which pm_req first rises)
//   ir_valid/ir_ready instruction handshake towards decode
//   instruction       instruction register; OP_dk = [15:8], OP_s = [15:12]
//   ir_pc             fetch address of the current instruction
//   pcInMux_ctrl      next-PC select: 00 RST_VEC, 01 branch_addr,
//                     10 acc_addr, 11 pc+1
//   branch_addr, acc_addr  next-PC candidates
//   flush/flush_addr  redirect request and target
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter int              PC_W    = 12,
   parameter logic [PC_W-1:0] RST_VEC = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            pm_req,
   output logic [PC_W-1:0] pm_addr,
   input  logic            pm_ack,
   input  logic [15:0]     pm_rdata,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic [15:0]     instruction,
   output logic [7:0]      OP_dk,
   output logic [3:0]      OP_s,
   output logic [PC_W-1:0] ir_pc,
   input  logic [1:0]      pcInMux_ctrl,
   input  logic [PC_W-1:0] branch_addr,
   input  logic [PC_W-1:0] acc_addr,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_addr
);

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH      = 2'd1,
      ISSUE      = 2'd2,
      DISCARD    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pm_addr_q, pm_addr_d;
   logic            pm_req_q, pm_req_d;
   logic            ir_valid_q, ir_valid_d;
   logic [15:0]     instr_q, instr_d;
   logic [PC_W-1:0] ir_pc_q, ir_pc_d;
   logic [PC_W-1:0] next_pc_s;

   // Next-PC multiplexer, used only on an accepted instruction handshake.
   always_comb begin
      next_pc_s = pc_q;
      case (pcInMux_ctrl)
         2'b00:   next_pc_s = RST_VEC;
         2'b01:   next_pc_s = branch_addr;
         2'b10:   next_pc_s = acc_addr;
         2'b11:   next_pc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
         default: next_pc_s = pc_q;
      endcase
   end

   // Fetch sequencer: next state, PC and instruction-register capture.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ir_pc_d = ir_pc_q;
      case (state_q)
         FETCH_IDLE: begin
            if (flush) begin
               pc_d = flush_addr;
            end else begin
               pc_d = pc_q;
            end
            state_d = FETCH;
         end
         FETCH: begin
            if (flush) begin
               pc_d = flush_addr;
               // An ack in the flush cycle closes the read, so a fresh
               // fetch can start at once; otherwise wait out the old read.
               if (pm_ack) begin
                  state_d = FETCH;
               end else begin
                  state_d = DISCARD;
               end
            end else if (pm_ack) begin
               instr_d = pm_rdata;
               ir_pc_d = pc_q;
               state_d = ISSUE;
            end else begin
               state_d = FETCH;
            end
         end
         ISSUE: begin
            if (flush) begin
               pc_d    = flush_addr;
               state_d = FETCH;
            end else if (ir_ready) begin
               pc_d    = next_pc_s;
               state_d = FETCH;
            end else begin
               state_d = ISSUE;
            end
         end
         DISCARD: begin
            if (flush) begin
               pc_d = flush_addr;
            end else begin
               pc_d = pc_q;
            end
            if (pm_ack) begin
               state_d = FETCH;
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   // Output flops derived from the next state. pm_addr is reloaded only when
   // entering FETCH, so it stays on the old address throughout DISCARD.
   always_comb begin
      pm_req_d   = (state_d == FETCH) || (state_d == DISCARD);
      ir_valid_d = (state_d == ISSUE);
      if (state_d == FETCH) begin
         pm_addr_d = pc_d;
      end else begin
         pm_addr_d = pm_addr_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RST_VEC;
         pm_addr_q  <= RST_VEC;
         pm_req_q   <= 1'b0;
         ir_valid_q <= 1'b0;
         instr_q    <= 16'h0000;
         ir_pc_q    <= {PC_W{1'b0}};
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pm_addr_q  <= pm_addr_d;
         pm_req_q   <= pm_req_d;
         ir_valid_q <= ir_valid_d;
         instr_q    <= instr_d;
         ir_pc_q    <= ir_pc_d;
      end
   end

   assign pm_req      = pm_req_q;
   assign pm_addr     = pm_addr_q;
   assign ir_valid    = ir_valid_q;
   assign instruction = instr_q;
   assign ir_pc       = ir_pc_q;
   assign OP_dk       = instr_q[15:8];
   assign OP_s        = instr_q[15:12];

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Randomised bench for instr_fetch. A transaction-level model tracks the
//   address the next fetch must start at, the open memory read (and whether
//   a flush has orphaned it) and the instruction decode should be seeing.
//   A memory responder acks each read after a chosen delay.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
   localparam int PC_W  = 12;
   localparam int AMOD  = 1 << PC_W;
   localparam logic [PC_W-1:0] RVEC = 12'h000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            pm_req;
   logic [PC_W-1:0] pm_addr;
   logic            pm_ack;
   logic [15:0]     pm_rdata;
   logic            ir_valid;
   logic            ir_ready;
   logic [15:0]     instruction;
   logic [7:0]      OP_dk;
   logic [3:0]      OP_s;
   logic [PC_W-1:0] ir_pc;
   logic [1:0]      pcInMux_ctrl;
   logic [PC_W-1:0] branch_addr;
   logic [PC_W-1:0] acc_addr;
   logic            flush;
   logic [PC_W-1:0] flush_addr;

   instr_fetch #(.PC_W(PC_W), .RST_VEC(RVEC)) dut (
      .clk(clk), .rst_n(rst_n),
      .pm_req(pm_req), .pm_addr(pm_addr), .pm_ack(pm_ack), .pm_rdata(pm_rdata),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .instruction(instruction),
      .OP_dk(OP_dk), .OP_s(OP_s), .ir_pc(ir_pc),
      .pcInMux_ctrl(pcInMux_ctrl), .branch_addr(branch_addr), .acc_addr(acc_addr),
      .flush(flush), .flush_addr(flush_addr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int          exp_next;
   bit          req_open, poisoned, exp_ir_valid, idle;
   int          req_addr, exp_ir_pc, wait_cnt, issued;
   logic [15:0] exp_instr;

   // knobs
   int knob_delay, knob_ready_pct, knob_flush_pct, knob_sel;
   bit force_flush;
   int force_addr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input int a);
      logic [31:0] t;
      if (a == 0) return 16'h7F88;
      t = (a * 32'd40503) ^ 32'h00005A5A;
      return t[15:0];
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_pm_req"}, {31'd0, pm_req}, 32'd0);
      check_val({tag, "_pm_addr"}, {20'd0, pm_addr}, {20'd0, RVEC});
      check_val({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
      check_val({tag, "_instr"}, {16'd0, instruction}, 32'd0);
      check_val({tag, "_ir_pc"}, {20'd0, ir_pc}, 32'd0);
   endtask

   // Assert reset mid-cycle with a stray ack present, check outputs at once.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      pm_ack = 1'b1;
      pm_rdata = 16'hDEAD;
      flush = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      pm_ack = 1'b0;
      rst_n = 1'b1;
      exp_next = int'(RVEC);
      req_open = 1'b0;
      poisoned = 1'b0;
      exp_ir_valid = 1'b0;
      idle = 1'b1;
   endtask

   // One clock: check outputs at the falling edge, drive inputs, advance model.
   task automatic run_cycle();
      bit ack, fl;
      int fa;
      @(negedge clk);
      check_val("ir_valid", {31'd0, ir_valid}, {31'd0, exp_ir_valid});
      if (exp_ir_valid) begin
         check_val("instruction", {16'd0, instruction}, {16'd0, exp_instr});
         check_val("ir_pc", {20'd0, ir_pc}, exp_ir_pc);
         check_val("OP_dk", {24'd0, OP_dk}, {16'd0, exp_instr} >> 8);
         check_val("OP_s", {28'd0, OP_s}, {16'd0, exp_instr} >> 12);
      end
      check_val("pm_req", {31'd0, pm_req}, {31'd0, (!exp_ir_valid && !idle)});
      if (pm_req) begin
         if (!req_open) begin
            check_val("fetch_addr", {20'd0, pm_addr}, exp_next);
            req_open = 1'b1;
            req_addr = int'(pm_addr);
            poisoned = 1'b0;
            wait_cnt = (knob_delay < 0) ? int'($urandom_range(0, 3)) : knob_delay;
         end else begin
            check_val("addr_hold", {20'd0, pm_addr}, req_addr);
         end
      end
      ack = req_open && pm_req && (wait_cnt == 0);
      if (req_open && wait_cnt > 0) wait_cnt--;
      pm_ack = ack;
      pm_rdata = mem_word(int'(pm_addr));
      ir_ready = ($urandom_range(0, 99) < knob_ready_pct);
      pcInMux_ctrl = (knob_sel < 0) ? 2'($urandom_range(0, 3)) : 2'(knob_sel);
      branch_addr = PC_W'($urandom_range(0, AMOD - 1));
      acc_addr = PC_W'($urandom_range(0, AMOD - 1));
      fl = force_flush || ($urandom_range(0, 99) < knob_flush_pct);
      fa = force_flush ? force_addr : int'($urandom_range(0, AMOD - 1));
      force_flush = 1'b0;
      flush = fl;
      flush_addr = PC_W'(fa);
      // transaction model
      if (fl) begin
         exp_next = fa;
         exp_ir_valid = 1'b0;
         if (req_open) begin
            if (ack) req_open = 1'b0;
            else poisoned = 1'b1;
         end
      end else if (ack) begin
         req_open = 1'b0;
         if (!poisoned) begin
            exp_ir_valid = 1'b1;
            exp_instr = mem_word(req_addr);
            exp_ir_pc = req_addr;
            issued++;
         end
      end else if (exp_ir_valid && ir_ready) begin
         exp_ir_valid = 1'b0;
         case (pcInMux_ctrl)
            2'b00:   exp_next = int'(RVEC);
            2'b01:   exp_next = int'(branch_addr);
            2'b10:   exp_next = int'(acc_addr);
            default: exp_next = (exp_ir_pc + 1) % AMOD;
         endcase
      end
      idle = 1'b0;
   endtask

   task automatic set_knobs(input int d, input int r, input int f, input int s);
      knob_delay = d; knob_ready_pct = r; knob_flush_pct = f; knob_sel = s;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      rst_n = 1'b0; pm_ack = 1'b0; pm_rdata = 16'h0000; ir_ready = 1'b0;
      pcInMux_ctrl = 2'b00; branch_addr = '0; acc_addr = '0;
      flush = 1'b0; flush_addr = '0; issued = 0; wait_cnt = 0;
      force_flush = 1'b0; force_addr = 0; exp_instr = 16'h0000; exp_ir_pc = 0;
      req_addr = 0;
      set_knobs(0, 100, 0, 3);
      #12;
      do_reset();
      // zero-wait fetch at 0 returning 7F88, then sequential pc+1
      run_n(8);
      // 3-cycle memory latency starting from 0x005
      set_knobs(3, 100, 0, 3);
      force_flush = 1'b1; force_addr = 12'h005;
      run_n(20);
      // wrap from 0xFFF, then branch targets
      set_knobs(0, 100, 0, 3);
      force_flush = 1'b1; force_addr = 12'hFFF;
      run_n(8);
      set_knobs(1, 100, 0, 1);
      run_n(10);
      // flush while a read is pending, decode stalled, then recover
      set_knobs(3, 100, 0, 3);
      force_flush = 1'b1; force_addr = 12'h010;
      run_n(2);
      force_flush = 1'b1; force_addr = 12'h040;
      run_n(12);
      set_knobs(0, 0, 0, 3);
      run_n(8);
      set_knobs(0, 100, 0, 3);
      force_flush = 1'b1; force_addr = 12'h080;
      run_n(6);
      // long random run
      set_knobs(-1, 60, 8, -1);
      run_n(3000);
      // reset mid-operation, then more random traffic
      do_reset();
      run_n(1);
      do_reset();
      set_knobs(-1, 50, 10, -1);
      run_n(1500);
      check_val("progress", {31'd0, (issued > 200)}, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
